// File: rtl/ifetch_queue.sv
// Sequential instruction fetcher: one outstanding req/ack memory access feeding a prefetch FIFO.
// Redirect flushes the FIFO; a response still in flight after a redirect is dropped.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   dat_mem [DEPTH];

  logic          pop, push;
  logic [31:0]   tgt_pc;
  logic [CW-1:0] count_after_pop, count_after_push;

  assign tgt_pc           = redirect_pc & ~32'h3;
  assign pop              = ins_valid && ins_ready;
  assign push             = (state_q == S_WAIT) && mem_ack && !redirect;
  assign count_after_pop  = count_q - CW'(pop);
  assign count_after_push = count_after_pop + CW'(push);

  assign mem_req   = (state_q != S_IDLE);
  assign mem_addr  = mem_addr_q;
  assign ins_valid = (count_q != '0);
  assign ins       = dat_mem[rd_ptr_q];
  assign ins_pc    = pc_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = tgt_pc;
        end else if (count_after_pop < DEPTH_C) begin
          mem_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = tgt_pc;
          state_d    = mem_ack ? S_IDLE : S_DROP;
        end else if (mem_ack) begin
          fetch_pc_d = mem_addr_q + 32'd4;
          // Chain the next request only if its response is guaranteed a slot.
          if (count_after_push < DEPTH_C) begin
            mem_addr_d = mem_addr_q + 32'd4;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          fetch_pc_d = tgt_pc;
        end
        if (mem_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_after_push;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= mem_addr_q;
      dat_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule
